block_data_memory: RTL
======================

BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16: bytes per line transfer; power of two, 4..64.
REQ-002 SHALL have parameter DEPTH_LINES, default 32768: lines stored; power of two.
REQ-003 SHALL have parameter READ_LATENCY, default 4: cycles BUSYWAIT is high for a read; range 1..15.
REQ-004 SHALL have parameter WRITE_LATENCY, default 4: cycles BUSYWAIT is high for a write; range 1..15.
REQ-005 SHALL derive ADDR_W = log2(DEPTH_LINES) and DATA_W = 8*LINE_BYTES.
REQ-006 CLK  input  1  sole clock; all state changes on rising edge.
REQ-007 RESET_N  input  1  asynchronous active-low reset.
REQ-008 READ  input  1  line read request, held until BUSYWAIT is sampled low.
REQ-009 WRITE  input  1  line write request, held until BUSYWAIT is sampled low.
REQ-010 ADDRESS  input  ADDR_W  line index, held stable with the request.
REQ-011 WRITE_DATA  input  DATA_W  write line; byte k occupies bits [8k+7:8k].
REQ-012 BYTE_EN  input  LINE_BYTES  per-byte write enable; bit k gates byte k.
REQ-013 READ_DATA  output  DATA_W  registered read line.
REQ-014 BUSYWAIT  output  1  high while an accepted or pending access is in progress.
REQ-015 ERROR  output  1  one-cycle pulse when READ and WRITE are sampled high together in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RBUSY, WBUSY, DONE, plus a 4-bit latency counter.
REQ-017 In IDLE, BUSYWAIT SHALL be combinationally high when exactly one of READ and WRITE is high, and low otherwise.
REQ-018 In IDLE at a rising edge, READ alone SHALL go to RBUSY, and WRITE alone SHALL go to WBUSY. Both SHALL latch ADDRESS. WBUSY SHALL also latch WRITE_DATA and BYTE_EN. Both SHALL load the counter with LATENCY-1.
REQ-019 READ and WRITE both high in IDLE SHALL be rejected: state stays IDLE, BUSYWAIT stays low, and ERROR pulses high for the following cycle.
REQ-020 In RBUSY and WBUSY, BUSYWAIT SHALL be high. The counter SHALL decrement each edge. Later changes on the request inputs SHALL be ignored.
REQ-021 On the edge where the counter is 0, RBUSY SHALL load READ_DATA from the latched line and go to DONE.
REQ-022 On the edge where the counter is 0, WBUSY SHALL write each byte k with latched BYTE_EN[k]=1, leave the other bytes unchanged, and go to DONE.
REQ-023 With LATENCY=1, the FSM SHALL pass through RBUSY or WBUSY for zero cycles: the access completes at the accept edge and goes directly to DONE.
REQ-024 So BUSYWAIT SHALL be high for exactly LATENCY consecutive cycles per access, counted from the first cycle the request is visible.
REQ-025 In DONE, BUSYWAIT SHALL be low for exactly one cycle and requests SHALL be ignored. DONE SHALL always go to IDLE, where a still-asserted request starts a new access.
REQ-026 READ_DATA SHALL hold its value until the next read completes; writes SHALL NOT change READ_DATA.
REQ-027 A read to a line SHALL return the bytes of all writes to that line that completed earlier.

Reset
REQ-028 RESET_N low SHALL immediately force IDLE, counter 0, READ_DATA 0 and ERROR 0. BUSYWAIT SHALL then follow REQ-017 only.
REQ-029 Reset during WBUSY SHALL abort the write, with no byte of memory modified. Reset during RBUSY SHALL discard the read.
REQ-030 Memory contents SHALL NOT be cleared by reset; the bench initialises them by explicit writes.
REQ-031 The FSM SHALL leave IDLE only on the first rising edge after RESET_N is deasserted.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, DEFAULT_LINE_BYTES and DEFAULT_LATENCY, and a clog2 helper for sizing.
REQ-033 Storage SHALL be one sub-module, mem_line_array: synchronous byte-enabled line RAM with one write port and one registered read port.
REQ-034 Parameters outside their legal ranges SHALL be rejected by an elaboration-time check.

Verification
REQ-035 Defaults: write 0x00112233_44556677_8899AABB_CCDDEEFF to line 5, all BYTE_EN set, then read line 5. Required: BUSYWAIT high for 4 cycles on each access, and READ_DATA equals the written line.
REQ-036 Byte enable: line 7 holds all 0xAA. Write all 0x55 with BYTE_EN=0x00F0, then read line 7. Required: bytes 4..7 are 0x55 and the other bytes are 0xAA.
REQ-037 READ_LATENCY=1, WRITE_LATENCY=7: back-to-back read then write, with requests held through DONE. Required: BUSYWAIT pattern 1,0,1,1,1,1,1,1,1,0.
REQ-038 READ and WRITE raised together in IDLE. Required: ERROR pulses for 1 cycle, BUSYWAIT stays 0, and memory is unchanged.
REQ-039 RESET_N pulsed low in the 2nd WBUSY cycle of a write of 0xFF.. to line 3 that held 0. Required: BUSYWAIT is 0 after reset, and a following read of line 3 returns 0.
REQ-040 Highest address, DEPTH_LINES-1, written then read. Required: data round-trips correctly, and line 0 is unchanged.

Source files
------------

// File: rtl/block_data_memory_pkg.sv
// Shared types and sizing helpers for the line-oriented data memory.
// Pure declarations: no latency, no flow control.
package block_data_memory_pkg;

    localparam int DEFAULT_LINE_BYTES = 16;
    localparam int DEFAULT_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RBUSY = 2'd1,
        WBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/block_data_memory_mem_line_array.sv
// Byte-enabled line RAM: one synchronous write port, one registered read port.
// Write and read take effect on the enabling edge; no backpressure, rd_data holds between reads.
module mem_line_array #(
    parameter int LINE_BYTES  = 16,
    parameter int DEPTH_LINES = 32768,
    parameter int ADDR_W      = 15,
    localparam int DATA_W     = 8 * LINE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_LINES];

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/block_data_memory.sv
// Line data memory with fixed-latency read/write handshake (BUSYWAIT high LATENCY cycles per access).
// Requests are held by the requester until BUSYWAIT is sampled low; one idle DONE cycle follows each access.
module block_data_memory
    import block_data_memory_pkg::*;
#(
    parameter int LINE_BYTES    = DEFAULT_LINE_BYTES,
    parameter int DEPTH_LINES   = 32768,
    parameter int READ_LATENCY  = DEFAULT_LATENCY,
    parameter int WRITE_LATENCY = DEFAULT_LATENCY,
    localparam int ADDR_W       = clog2(DEPTH_LINES),
    localparam int DATA_W       = 8 * LINE_BYTES
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [DATA_W-1:0]     WRITE_DATA,
    input  logic [LINE_BYTES-1:0] BYTE_EN,
    output logic [DATA_W-1:0]     READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  ERROR
);

    if (LINE_BYTES < 4 || LINE_BYTES > 64 || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_bad_line_bytes
        $error("LINE_BYTES must be a power of two in 4..64");
    end
    if (DEPTH_LINES < 2 || (DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_LINES must be a power of two, at least 2");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 15 || WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_latency
        $error("READ_LATENCY and WRITE_LATENCY must be in 1..15");
    end

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       data_q;
    logic [LINE_BYTES-1:0]   be_q;
    logic                    req_rd;
    logic                    req_wr;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    in_idle;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [LINE_BYTES-1:0]   mem_be;

    assign in_idle = (state == IDLE);
    assign req_rd  = in_idle && READ && !WRITE;
    assign req_wr  = in_idle && WRITE && !READ;

    // The IDLE request cycle is the first busy cycle, so the busy state lasts
    // LATENCY-1 cycles and completes on the edge that takes the counter to 0.
    // Unit latency therefore completes straight from IDLE using the live inputs.
    assign rd_fire = (req_rd && READ_LATENCY == 1) || (state == RBUSY && cnt == 4'd1);
    assign wr_fire = (req_wr && WRITE_LATENCY == 1) || (state == WBUSY && cnt == 4'd1);

    assign mem_addr  = in_idle ? ADDRESS    : addr_q;
    assign mem_wdata = in_idle ? WRITE_DATA : data_q;
    assign mem_be    = in_idle ? BYTE_EN    : be_q;

    always_comb begin
        BUSYWAIT = 1'b0;
        case (state)
            IDLE:         BUSYWAIT = READ ^ WRITE;
            RBUSY, WBUSY: BUSYWAIT = 1'b1;
            default:      BUSYWAIT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            ERROR  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            ERROR <= in_idle && READ && WRITE;
            case (state)
                IDLE: begin
                    if (req_rd) begin
                        addr_q <= ADDRESS;
                        cnt    <= RD_LOAD;
                        state  <= (READ_LATENCY == 1) ? DONE : RBUSY;
                    end else if (req_wr) begin
                        addr_q <= ADDRESS;
                        data_q <= WRITE_DATA;
                        be_q   <= BYTE_EN;
                        cnt    <= WR_LOAD;
                        state  <= (WRITE_LATENCY == 1) ? DONE : WBUSY;
                    end
                end
                RBUSY, WBUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_line_array #(
        .LINE_BYTES  (LINE_BYTES),
        .DEPTH_LINES (DEPTH_LINES),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .wr_en   (wr_fire),
        .wr_addr (mem_addr),
        .wr_data (mem_wdata),
        .wr_be   (mem_be),
        .rd_en   (rd_fire),
        .rd_addr (mem_addr),
        .rd_data (READ_DATA)
    );

endmodule
